ddr4_cmd_scheduler: RTL and testbench

- Sequences DDR4 commands for one rank between the host command interface and the PHY command interface.
- Tracks open/closed state and open row for each bank.
- Decides per request whether to issue ACT, PRE+ACT or a direct RD/WR, enforcing tRCD, tRP, tRAS, tCCD and tRFC.
- Arbitrates between host requests and the refresh controller's ref_req/ref_ack handshake; refresh wins at request boundaries.

---
 rtl/ddr4_pkg.sv | 31 +++
 rtl/bank_state_tracker.sv | 72 +++++++
 rtl/ddr4_cmd_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_ddr4_cmd_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_pkg.sv
// Shared definitions for the DDR4 command scheduler: PHY command
// encodings, FSM states and timing helpers.
package ddr4_pkg;

    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_ZQ  = 3'b110;
    localparam logic [2:0] CMD_NOP = 3'b111;

    localparam int PREA_BIT = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_RW,
        S_REF_PREA,
        S_REF,
        S_WAIT
    } state_e;

    // A programmed timing of zero behaves as one cycle.
    function automatic logic [15:0] t_eff(input logic [15:0] t);
        return (t == 16'd0) ? 16'd1 : t;
    endfunction

endpackage

// File: rtl/bank_state_tracker.sv
// Per-bank open flag, open row and tRAS down-counter, with lookup
// of the addressed bank and an all-banks tRAS-satisfied flag.
module bank_state_tracker
    import ddr4_pkg::*;
#(
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH  = 16,
    parameter int NUM_BANKS  = 2 ** BANK_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BANK_WIDTH-1:0] lk_bank_i,
    input  logic [ROW_WIDTH-1:0]  lk_row_i,
    input  logic [BANK_WIDTH-1:0] cmd_bank_i,
    input  logic [ROW_WIDTH-1:0]  act_row_i,
    input  logic                  act_en_i,
    input  logic                  pre_en_i,
    input  logic                  prea_en_i,
    input  logic [7:0]            t_ras_i,
    output logic                  hit_o,
    output logic                  open_o,
    output logic                  ras_done_o,
    output logic                  all_ras_done_o,
    output logic                  any_open_o
);

    logic [NUM_BANKS-1:0]                open_q;
    logic [NUM_BANKS-1:0][ROW_WIDTH-1:0] row_q;
    logic [NUM_BANKS-1:0][7:0]           ras_q;

    logic [7:0] ras_ld;
    assign ras_ld = 8'(t_eff(16'(t_ras_i)) - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            open_q <= '0;
            row_q  <= '0;
            ras_q  <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (act_en_i && cmd_bank_i == BANK_WIDTH'(b)) begin
                    open_q[b] <= 1'b1;
                    row_q[b]  <= act_row_i;
                    ras_q[b]  <= ras_ld;
                end else begin
                    if (ras_q[b] != 8'd0) begin
                        ras_q[b] <= ras_q[b] - 8'd1;
                    end
                    if (prea_en_i ||
                        (pre_en_i && cmd_bank_i == BANK_WIDTH'(b))) begin
                        open_q[b] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        all_ras_done_o = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (ras_q[b] != 8'd0) begin
                all_ras_done_o = 1'b0;
            end
        end
    end

    assign open_o     = open_q[lk_bank_i];
    assign hit_o      = open_q[lk_bank_i] && row_q[lk_bank_i] == lk_row_i;
    assign ras_done_o = ras_q[lk_bank_i] == 8'd0;
    assign any_open_o = |open_q;

endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// Single-rank DDR4 command scheduler: open-page policy with per-bank
// row tracking, timing enforcement and refresh arbitration.
module ddr4_cmd_scheduler
    import ddr4_pkg::*;
#(
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH  = 16,
    parameter int COL_WIDTH  = 10,
    parameter int NUM_BANKS  = 2 ** BANK_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_done,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [BANK_WIDTH-1:0] req_bank,
    input  logic [ROW_WIDTH-1:0]  req_row,
    input  logic [COL_WIDTH-1:0]  req_col,
    output logic                  req_ready,
    input  logic                  ref_req,
    output logic                  ref_ack,
    input  logic [7:0]            t_rcd,
    input  logic [7:0]            t_rp,
    input  logic [7:0]            t_ras,
    input  logic [7:0]            t_ccd,
    input  logic [15:0]           t_rfc,
    output logic [2:0]            phy_cmd,
    output logic [15:0]           phy_addr,
    output logic [1:0]            phy_bank,
    output logic                  phy_bg,
    output logic                  phy_act_n,
    output logic                  phy_cs_n,
    output logic                  busy
);

    state_e                state_q, tgt_q, tgt_d;
    logic [15:0]           wait_q, tsel_d, ld_d;
    logic                  wr_q;
    logic [BANK_WIDTH-1:0] bank_q, lk_bank;
    logic [ROW_WIDTH-1:0]  row_q, lk_row;
    logic [COL_WIDTH-1:0]  col_q;

    logic [2:0]  cmd_q;
    logic [15:0] addr_q;
    logic [1:0]  pbank_q;
    logic        bg_q, act_n_q, cs_n_q, ack_q;

    logic idle_go, accept, ref_go;
    logic act_en, pre_en, prea_en, rw_en, ref_en, issue;
    logic hit, bank_open, ras_done, all_ras_done, any_open;

    assign idle_go   = !reset && init_done &&
                       state_q == S_IDLE && wait_q == 16'd0;
    assign req_ready = idle_go && !ref_req;
    assign accept    = req_ready && req_valid;
    assign ref_go    = idle_go && ref_req;

    assign act_en  = state_q == S_ACT && wait_q == 16'd0;
    assign pre_en  = state_q == S_PRE && wait_q == 16'd0 && ras_done;
    assign prea_en = state_q == S_REF_PREA && wait_q == 16'd0 &&
                     all_ras_done;
    assign rw_en   = state_q == S_RW && wait_q == 16'd0;
    assign ref_en  = state_q == S_REF && wait_q == 16'd0;
    assign issue   = act_en | pre_en | prea_en | rw_en | ref_en;

    assign lk_bank = (state_q == S_IDLE) ? req_bank : bank_q;
    assign lk_row  = (state_q == S_IDLE) ? req_row : row_q;

    bank_state_tracker #(
        .BANK_WIDTH(BANK_WIDTH),
        .ROW_WIDTH (ROW_WIDTH),
        .NUM_BANKS (NUM_BANKS)
    ) u_banks (
        .clk           (clk),
        .reset         (reset),
        .lk_bank_i     (lk_bank),
        .lk_row_i      (lk_row),
        .cmd_bank_i    (bank_q),
        .act_row_i     (row_q),
        .act_en_i      (act_en),
        .pre_en_i      (pre_en),
        .prea_en_i     (prea_en),
        .t_ras_i       (t_ras),
        .hit_o         (hit),
        .open_o        (bank_open),
        .ras_done_o    (ras_done),
        .all_ras_done_o(all_ras_done),
        .any_open_o    (any_open)
    );

    // Waits ending in IDLE count one extra cycle so the request gate
    // (wait == 0 in IDLE) opens exactly T cycles after the command.
    always_comb begin
        tsel_d = 16'd1;
        tgt_d  = S_IDLE;
        unique case (state_q)
            S_PRE:      begin tsel_d = 16'(t_rp);  tgt_d = S_ACT; end
            S_REF_PREA: begin tsel_d = 16'(t_rp);  tgt_d = S_REF; end
            S_ACT:      begin tsel_d = 16'(t_rcd); tgt_d = S_RW;  end
            S_RW:       begin tsel_d = 16'(t_ccd); tgt_d = S_IDLE; end
            S_REF:      begin tsel_d = t_rfc;      tgt_d = S_IDLE; end
            default:    ;
        endcase
        ld_d = (tgt_d == S_IDLE) ? t_eff(tsel_d) : t_eff(tsel_d) - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tgt_q   <= S_IDLE;
            wait_q  <= '0;
            wr_q    <= 1'b0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            pbank_q <= '0;
            bg_q    <= 1'b0;
            act_n_q <= 1'b1;
            cs_n_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            pbank_q <= '0;
            bg_q    <= 1'b0;
            act_n_q <= 1'b1;
            cs_n_q  <= 1'b1;
            ack_q   <= 1'b0;
            if (wait_q != 16'd0) begin
                wait_q <= wait_q - 16'd1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (ref_go) begin
                        state_q <= any_open ? S_REF_PREA : S_REF;
                    end else if (accept) begin
                        wr_q    <= req_write;
                        bank_q  <= req_bank;
                        row_q   <= req_row;
                        col_q   <= req_col;
                        state_q <= hit ? S_RW :
                                   bank_open ? S_PRE : S_ACT;
                    end
                end
                S_PRE: begin
                    if (pre_en) begin
                        cmd_q   <= CMD_PRE;
                        cs_n_q  <= 1'b0;
                        pbank_q <= bank_q[1:0];
                        bg_q    <= bank_q[BANK_WIDTH-1];
                    end
                end
                S_REF_PREA: begin
                    if (prea_en) begin
                        cmd_q            <= CMD_PRE;
                        cs_n_q           <= 1'b0;
                        addr_q[PREA_BIT] <= 1'b1;
                    end
                end
                S_ACT: begin
                    if (act_en) begin
                        cmd_q   <= CMD_ACT;
                        cs_n_q  <= 1'b0;
                        act_n_q <= 1'b0;
                        addr_q  <= 16'(row_q);
                        pbank_q <= bank_q[1:0];
                        bg_q    <= bank_q[BANK_WIDTH-1];
                    end
                end
                S_RW: begin
                    if (rw_en) begin
                        cmd_q   <= wr_q ? CMD_WR : CMD_RD;
                        cs_n_q  <= 1'b0;
                        addr_q  <= 16'(col_q);
                        pbank_q <= bank_q[1:0];
                        bg_q    <= bank_q[BANK_WIDTH-1];
                    end
                end
                S_REF: begin
                    if (ref_en) begin
                        cmd_q  <= CMD_REF;
                        cs_n_q <= 1'b0;
                        ack_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_q <= 16'd1) begin
                        state_q <= tgt_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (issue) begin
                wait_q  <= ld_d;
                tgt_q   <= tgt_d;
                state_q <= (ld_d == 16'd0) ? tgt_d : S_WAIT;
            end
        end
    end

    assign phy_cmd   = cmd_q;
    assign phy_addr  = addr_q;
    assign phy_bank  = pbank_q;
    assign phy_bg    = bg_q;
    assign phy_act_n = act_n_q;
    assign phy_cs_n  = cs_n_q;
    assign ref_ack   = ack_q;
    assign busy      = state_q != S_IDLE;

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Directed self-checking bench for ddr4_cmd_scheduler covering
// row miss/hit/conflict, refresh arbitration and mid-op reset.
module tb_ddr4_cmd_scheduler;
    import ddr4_pkg::*;

    logic        clk = 1'b0;
    logic        reset, init_done, req_valid, req_write, ref_req;
    logic [2:0]  req_bank;
    logic [15:0] req_row;
    logic [9:0]  req_col;
    logic        req_ready, ref_ack, phy_bg, phy_act_n, phy_cs_n, busy;
    logic [7:0]  t_rcd, t_rp, t_ras, t_ccd;
    logic [15:0] t_rfc, phy_addr;
    logic [2:0]  phy_cmd;
    logic [1:0]  phy_bank;

    ddr4_cmd_scheduler dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .req_valid(req_valid), .req_write(req_write),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .req_ready(req_ready), .ref_req(ref_req), .ref_ack(ref_ack),
        .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_ccd(t_ccd),
        .t_rfc(t_rfc), .phy_cmd(phy_cmd), .phy_addr(phy_addr),
        .phy_bank(phy_bank), .phy_bg(phy_bg), .phy_act_n(phy_act_n),
        .phy_cs_n(phy_cs_n), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pin-level consistency on every cycle: cs_n and act_n follow cmd.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (phy_cs_n !== (phy_cmd == CMD_NOP) ||
                phy_act_n !== (phy_cmd != CMD_ACT))
                $display("FAIL pins cyc=%0d cmd=%b cs_n=%b act_n=%b need cs_n=%b act_n=%b",
                         cyc, phy_cmd, phy_cs_n, phy_act_n,
                         phy_cmd == CMD_NOP, phy_cmd != CMD_ACT);
            else passed++;
        end
    end

    logic [2:0]  o_cmd;
    logic [15:0] o_addr;
    logic [1:0]  o_bank;
    logic        o_bg, o_act_n, o_ack;
    int          o_at;

    task automatic next_cmd();
        bit got = 0;
        o_cmd = CMD_NOP; o_addr = '0; o_bank = '0;
        o_bg = 0; o_act_n = 1; o_ack = 0; o_at = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (phy_cs_n == 1'b0) begin
                got = 1;
                o_cmd = phy_cmd; o_addr = phy_addr; o_bank = phy_bank;
                o_bg = phy_bg; o_act_n = phy_act_n; o_ack = ref_ack;
                o_at = cyc;
            end
        end
    endtask

    task automatic send_req(input logic w, input logic [2:0] b,
                            input logic [15:0] r, input logic [9:0] c);
        bit ok = 0;
        @(negedge clk);
        req_valid = 1; req_write = w; req_bank = b; req_row = r; req_col = c;
        for (int i = 0; i < 400 && !ok; i++) begin
            #1;
            if (req_ready) ok = 1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) $display("FAIL accept_timeout bank=%0d ready=0 need 1", b);
        else passed++;
        @(negedge clk);
        req_valid = 0; req_write = ~w; req_bank = ~b;
        req_row = 16'hDEAD; req_col = 10'h3FF;
    endtask

    task automatic test_reset();
        bit seen = 0;
        reset = 1; init_done = 0; req_valid = 0; req_write = 0;
        req_bank = 0; req_row = 0; req_col = 0; ref_req = 0;
        t_rcd = 8'd4; t_rp = 8'd5; t_ras = 8'd20; t_ccd = 8'd4;
        t_rfc = 16'd100;
        repeat (3) @(negedge clk);
        checks++;
        if ({phy_cmd, phy_addr, phy_bank, phy_bg} !== {CMD_NOP, 19'd0})
            $display("FAIL reset_cmd cmd=%b addr=%h bank=%0d bg=%b need 111/0/0/0",
                     phy_cmd, phy_addr, phy_bank, phy_bg);
        else passed++;
        checks++;
        if ({phy_act_n, phy_cs_n, req_ready, ref_ack, busy} !== 5'b11000)
            $display("FAIL reset_ctl act_n,cs_n,ready,ack,busy=%b need 11000",
                     {phy_act_n, phy_cs_n, req_ready, ref_ack, busy});
        else passed++;
        mon_en = 1;
        reset = 0; req_valid = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_ready || !phy_cs_n) seen = 1;
        end
        checks++;
        if (seen) $display("FAIL pre_init_activity seen=1 need 0");
        else passed++;
        req_valid = 0; init_done = 1;
    endtask

    int act_a;

    task automatic test_miss_act();
        send_req(1'b0, 3'd0, 16'h0012, 10'h040);
        next_cmd();
        act_a = o_at;
        checks++;
        if ({o_cmd, o_addr, o_bank, o_bg, o_act_n} !== {CMD_ACT, 16'h0012, 2'd0, 1'b0, 1'b0})
            $display("FAIL miss_act cmd=%b addr=%h act_n=%b need 011/0012/0",
                     o_cmd, o_addr, o_act_n);
        else passed++;
        next_cmd();
        checks++;
        if (o_cmd !== CMD_RD || o_addr !== 16'h0040)
            $display("FAIL miss_rd cmd=%b addr=%h need 101/0040", o_cmd, o_addr);
        else passed++;
        checks++;
        if (o_at - act_a !== 4)
            $display("FAIL trcd gap=%0d need 4", o_at - act_a);
        else passed++;
    endtask

    task automatic test_hit();
        int rd;
        send_req(1'b0, 3'd0, 16'h0012, 10'h041);
        next_cmd();
        rd = o_at;
        checks++;
        if (o_cmd !== CMD_RD || o_addr !== 16'h0041)
            $display("FAIL hit_rd cmd=%b addr=%h need 101/0041", o_cmd, o_addr);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== (k == 4))
                $display("FAIL tccd_ready rd+%0d ready=%b need %b",
                         k, req_ready, k == 4);
            else passed++;
        end
        checks++;
        if (cyc - rd !== 4) $display("FAIL hit_cycle off=%0d need 4", cyc - rd);
        else passed++;
    endtask

    task automatic test_conflict();
        int pre_at, act_at;
        send_req(1'b1, 3'd0, 16'h0034, 10'h007);
        next_cmd();
        pre_at = o_at;
        checks++;
        if (o_cmd !== CMD_PRE || o_addr[10] !== 1'b0)
            $display("FAIL conf_pre cmd=%b a10=%b need 010/0", o_cmd, o_addr[10]);
        else passed++;
        checks++;
        if (pre_at - act_a < 20)
            $display("FAIL tras gap=%0d need >=20", pre_at - act_a);
        else passed++;
        next_cmd();
        act_at = o_at;
        checks++;
        if (o_cmd !== CMD_ACT || o_addr !== 16'h0034 || act_at - pre_at !== 5)
            $display("FAIL conf_act cmd=%b addr=%h gap=%0d need 011/0034/5",
                     o_cmd, o_addr, act_at - pre_at);
        else passed++;
        next_cmd();
        checks++;
        if (o_cmd !== CMD_WR || o_addr !== 16'h0007 || o_at - act_at !== 4)
            $display("FAIL conf_wr cmd=%b addr=%h gap=%0d need 100/0007/4",
                     o_cmd, o_addr, o_at - act_at);
        else passed++;
    endtask

    task automatic test_refresh();
        int act5, pa, rf;
        send_req(1'b0, 3'd5, 16'h0055, 10'h003);
        next_cmd();
        act5 = o_at;
        checks++;
        if (o_cmd !== CMD_ACT || o_bank !== 2'd1 || o_bg !== 1'b1)
            $display("FAIL b5_act cmd=%b bank=%0d bg=%b need 011/1/1",
                     o_cmd, o_bank, o_bg);
        else passed++;
        next_cmd();
        ref_req = 1;
        next_cmd();
        pa = o_at;
        checks++;
        if (o_cmd !== CMD_PRE || o_addr !== 16'h0400 || o_ack !== 1'b0)
            $display("FAIL prea cmd=%b addr=%h ack=%b need 010/0400/0",
                     o_cmd, o_addr, o_ack);
        else passed++;
        checks++;
        if (pa - act5 < 20) $display("FAIL prea_tras gap=%0d need >=20", pa - act5);
        else passed++;
        next_cmd();
        rf = o_at;
        ref_req = 0;
        checks++;
        if (o_cmd !== CMD_REF || o_ack !== 1'b1 || rf - pa !== 5)
            $display("FAIL ref cmd=%b ack=%b gap=%0d need 001/1/5",
                     o_cmd, o_ack, rf - pa);
        else passed++;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (ref_ack !== 1'b0) $display("FAIL ack_pulse ack=%b need 0", ref_ack);
                else passed++;
            end
            if (k == 50) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL busy_trfc busy=%b need 1", busy);
                else passed++;
            end
            if (k == 99 || k == 100) begin
                checks++;
                if (req_ready !== (k == 100) || busy !== (k != 100))
                    $display("FAIL trfc_ready ref+%0d ready=%b busy=%b need %b/%b",
                             k, req_ready, busy, k == 100, k != 100);
                else passed++;
            end
        end
        send_req(1'b0, 3'd5, 16'h0055, 10'h004);
        next_cmd();
        checks++;
        if (o_cmd !== CMD_ACT || o_addr !== 16'h0055)
            $display("FAIL b5_reopen cmd=%b addr=%h need 011/0055", o_cmd, o_addr);
        else passed++;
        next_cmd();
        checks++;
        if (o_cmd !== CMD_RD || o_addr !== 16'h0004)
            $display("FAIL b5_rd cmd=%b addr=%h need 101/0004", o_cmd, o_addr);
        else passed++;
    endtask

    task automatic test_ref_priority();
        int rf;
        bit ok = 0;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        ref_req = 1; req_valid = 1; req_write = 0;
        req_bank = 3'd2; req_row = 16'h0009; req_col = 10'h005;
        #1;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL ref_wins ready=%b need 0", req_ready);
        else passed++;
        next_cmd();
        checks++;
        if (o_cmd !== CMD_PRE || o_addr !== 16'h0400)
            $display("FAIL prio_prea cmd=%b addr=%h need 010/0400", o_cmd, o_addr);
        else passed++;
        next_cmd();
        rf = o_at;
        ref_req = 0;
        checks++;
        if (o_cmd !== CMD_REF || o_ack !== 1'b1)
            $display("FAIL prio_ref cmd=%b ack=%b need 001/1", o_cmd, o_ack);
        else passed++;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        @(negedge clk);
        req_valid = 0; req_bank = 3'd7; req_row = 16'hBEEF;
        next_cmd();
        checks++;
        if (!ok || o_cmd !== CMD_ACT || o_addr !== 16'h0009 ||
            o_bank !== 2'd2 || o_bg !== 1'b0 || o_at - rf < 100)
            $display("FAIL prio_act ok=%b cmd=%b addr=%h bank=%0d gap=%0d need 1/011/0009/2/>=100",
                     ok, o_cmd, o_addr, o_bank, o_at - rf);
        else passed++;
        next_cmd();
        checks++;
        if (o_cmd !== CMD_RD || o_addr !== 16'h0005)
            $display("FAIL prio_rd cmd=%b addr=%h need 101/0005", o_cmd, o_addr);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        send_req(1'b0, 3'd3, 16'h0066, 10'h008);
        next_cmd();
        checks++;
        if (o_cmd !== CMD_ACT) $display("FAIL mid_act cmd=%b need 011", o_cmd);
        else passed++;
        reset = 1;
        @(negedge clk);
        checks++;
        if ({phy_cmd, phy_addr, phy_cs_n, phy_act_n, busy, req_ready, ref_ack}
            !== {CMD_NOP, 16'd0, 5'b11000})
            $display("FAIL mid_reset cmd=%b addr=%h cs_n=%b busy=%b ready=%b need 111/0/1/0/0",
                     phy_cmd, phy_addr, phy_cs_n, busy, req_ready);
        else passed++;
        reset = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!phy_cs_n) n++;
        end
        checks++;
        if (n != 0) $display("FAIL mid_no_rd cmds=%0d need 0", n);
        else passed++;
        send_req(1'b0, 3'd3, 16'h0066, 10'h009);
        next_cmd();
        checks++;
        if (o_cmd !== CMD_ACT || o_addr !== 16'h0066 || o_bank !== 2'd3)
            $display("FAIL mid_closed cmd=%b addr=%h bank=%0d need 011/0066/3",
                     o_cmd, o_addr, o_bank);
        else passed++;
        next_cmd();
        checks++;
        if (o_cmd !== CMD_RD || o_addr !== 16'h0009)
            $display("FAIL mid_rd cmd=%b addr=%h need 101/0009", o_cmd, o_addr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_miss_act();
        test_hit();
        test_conflict();
        test_refresh();
        test_ref_priority();
        test_reset_mid();
        repeat (2) @(negedge clk);
        mon_en = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout passed=%0d checks=%0d", passed, checks);
        $fatal(1);
    end

endmodule
